quadrature_decoder: RTL and testbench

//   Decodes a two-phase quadrature pair (A/B) into single-cycle step pulses and a

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/quad_glitch_filter.sv | 59 +++++
 rtl/quadrature_decoder.sv | 132 +++++++++++++
 tb/tb_quadrature_decoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Package: quad_pkg
// Purpose: shared definitions for the quadrature decoder.
//   - FSM state encoding (ARMING, RUN)
//   - direction constants for the dir output
//   - two-bit phase-state constants ({A,B}) and the forward/reverse
//     successor lookups used to classify transitions
package quad_pkg;

    typedef enum logic {
        ARMING = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;

    // Forward rotation (A leads B): 00 -> 10 -> 11 -> 01 -> 00
    function automatic logic [1:0] next_up(input logic [1:0] s);
        case (s)
            PH_00:   return PH_10;
            PH_10:   return PH_11;
            PH_11:   return PH_01;
            default: return PH_00;
        endcase
    endfunction

    // Reverse rotation: 00 -> 01 -> 11 -> 10 -> 00
    function automatic logic [1:0] next_down(input logic [1:0] s);
        case (s)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Module: quad_glitch_filter
// Purpose: one encoder channel's front end. A raw asynchronous input is
//   passed through a SYNC_STAGES flop synchroniser, then a stability
//   counter only lets the filtered level follow the synced level after it
//   has disagreed for FILTER_LEN consecutive cycles.
// Ports:
//   clk         in  rising-edge clock
//   clear       in  asynchronous reset, active-high
//   raw         in  raw channel input, asynchronous to clk
//   force_load  in  copy the synced level straight into the filter
//   synced      out output of the last synchroniser stage
//   filtered    out debounced level
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic clear,
    input  logic raw,
    input  logic force_load,
    output logic synced,
    output logic filtered
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // The level is accepted on the FILTER_LEN-th consecutive disagreeing
    // cycle, so a pulse of FILTER_LEN-1 cycles never reaches the output.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            filtered <= 1'b0;
            cnt      <= '0;
        end else if (force_load) begin
            filtered <= synced;
            cnt      <= '0;
        end else if (synced == filtered) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
            filtered <= synced;
            cnt      <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// Module: quadrature_decoder
// Purpose: decodes a two-phase quadrature pair into single-cycle step
//   pulses, a held direction bit and an error pulse, and keeps a loadable
//   wrap-around position count.
// Ports:
//   clk    in   rising-edge clock
//   clear  in   asynchronous reset, active-high
//   a_in   in   raw phase A (asynchronous)
//   b_in   in   raw phase B (asynchronous)
//   load   in   synchronous load of pos from d (wins over counting)
//   d      in   load value
//   step   out  one-cycle pulse per valid transition
//   dir    out  1 = up (A leads B), 0 = down; held between steps
//   err    out  one-cycle pulse on an illegal two-bit transition
//   pos    out  position count, wraps modulo 2^WIDTH
module quadrature_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [WIDTH-1:0] pos
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);

    state_t           state, state_nxt;
    logic [ARM_W-1:0] arm_cnt;
    logic             arm_load;
    logic             a_sync, b_sync, a_filt, b_filt;
    logic [1:0]       cur, prev, prev_nxt;
    logic             step_nxt, err_nxt, dir_nxt;
    logic [WIDTH-1:0] pos_nxt;

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .clear(clear), .raw(a_in), .force_load(arm_load),
        .synced(a_sync), .filtered(a_filt)
    );

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .clear(clear), .raw(b_in), .force_load(arm_load),
        .synced(b_sync), .filtered(b_filt)
    );

    assign cur = {a_filt, b_filt};

    // The arming counter only runs out of reset; once the synchroniser is
    // full, whatever level the inputs sit at becomes the reference state,
    // so a stuck or parked encoder never produces a spurious step or err.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= ARMING;
            arm_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARMING && !arm_load) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end else begin
                arm_cnt <= '0;
            end
        end
    end

    // Transition classification. step/err/dir/pos are all registered so
    // pos changes in the very cycle the step pulse is visible.
    always_comb begin
        state_nxt = state;
        arm_load  = 1'b0;
        step_nxt  = 1'b0;
        err_nxt   = 1'b0;
        dir_nxt   = dir;
        pos_nxt   = pos;
        prev_nxt  = prev;
        case (state)
            ARMING: begin
                if (arm_cnt == ARM_W'(SYNC_STAGES)) begin
                    arm_load  = 1'b1;
                    prev_nxt  = {a_sync, b_sync};
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cur != prev) begin
                    prev_nxt = cur;
                    if (cur == next_up(prev)) begin
                        step_nxt = 1'b1;
                        dir_nxt  = DIR_UP;
                        pos_nxt  = pos + WIDTH'(1);
                    end else if (cur == next_down(prev)) begin
                        step_nxt = 1'b1;
                        dir_nxt  = DIR_DOWN;
                        pos_nxt  = pos - WIDTH'(1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ARMING;
        endcase
        // A load overrides the count but the pulses are still reported.
        if (load) begin
            pos_nxt = d;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            step <= 1'b0;
            err  <= 1'b0;
            dir  <= DIR_DOWN;
            pos  <= '0;
            prev <= PH_00;
        end else begin
            step <= step_nxt;
            err  <= err_nxt;
            dir  <= dir_nxt;
            pos  <= pos_nxt;
            prev <= prev_nxt;
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Testbench: tb_quadrature_decoder
// Purpose: table-driven and hand-sequenced checks of quadrature_decoder with
//   default parameters. Every input edge that should produce a pulse pushes
//   its expected cycle, pulse type, dir and pos onto a scoreboard; a
//   negedge monitor pops one entry per observed pulse and flags any pulse
//   that nothing expected.
module tb_quadrature_decoder;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 6;

    logic             clk = 1'b0;
    logic             clear;
    logic             a_in, b_in, load;
    logic [WIDTH-1:0] d;
    logic             step, dir, err;
    logic [WIDTH-1:0] pos;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int               due;
        logic             step;
        logic             err;
        logic             dir;
        logic [WIDTH-1:0] pos;
    } exp_t;

    typedef struct {
        logic             a;
        logic             b;
        logic             dir;
        logic [WIDTH-1:0] pos;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    quadrature_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk(clk), .clear(clear), .a_in(a_in), .b_in(b_in),
        .load(load), .d(d), .step(step), .dir(dir), .err(err), .pos(pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Drive a new A/B level at a negedge and optionally queue the pulse it
    // should cause LATENCY cycles later, then hold for 'hold' cycles.
    task automatic applyStimulus(input logic na, input logic nb, input logic expect_pulse,
                                 input logic es, input logic ee, input logic ed,
                                 input logic [WIDTH-1:0] ep, input int hold);
        exp_t e;
        a_in = na;
        b_in = nb;
        if (expect_pulse) begin
            e.due  = cyc + LATENCY;
            e.step = es;
            e.err  = ee;
            e.dir  = ed;
            e.pos  = ep;
            sb.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: %0d expected pulses never seen, expected 0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (step || err) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_pulse: step=%0d err=%0d at cycle %0d, expected none",
                         step, err, cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("latency_cycle", cyc, mon_e.due);
                checkOutput("step", {31'd0, step}, {31'd0, mon_e.step});
                checkOutput("err", {31'd0, err}, {31'd0, mon_e.err});
                checkOutput("dir", {31'd0, dir}, {31'd0, mon_e.dir});
                checkOutput("pos", {24'd0, pos}, {24'd0, mon_e.pos});
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 8'd1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'd2};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd3};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 8'd4};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'd3};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'd2};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 8'd255};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 8'd254};

        clear = 1'b1;
        a_in  = 1'b0;
        b_in  = 1'b0;
        load  = 1'b0;
        d     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_step", {31'd0, step}, 0);
        checkOutput("reset_err", {31'd0, err}, 0);
        checkOutput("reset_dir", {31'd0, dir}, 0);
        checkOutput("reset_pos", {24'd0, pos}, 0);
        clear = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] forward then reverse rotation");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b1, 1'b1, 1'b0, vecs[i].dir, vecs[i].pos, 8);
            if (i == 3) begin
                checkOutput("dir_after_fwd", {31'd0, dir}, 1);
                checkOutput("pos_after_fwd", {24'd0, pos}, 4);
            end
        end
        checkOutput("dir_after_rev", {31'd0, dir}, 0);
        checkOutput("pos_after_rev", {24'd0, pos}, 254);

        $display("[TB] two-bit jump 11 -> 00");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd254, 10);

        $display("[TB] glitch filter: 2-cycle pulse rejected, 3-cycle pulse accepted");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 12);
        checkOutput("short_pulse_pos", {24'd0, pos}, 254);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd255, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd254, 12);

        $display("[TB] load coincident with step");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 5);
        load = 1'b1;
        d    = 8'h80;
        @(negedge clk);
        load = 1'b0;
        d    = 8'h00;
        repeat (6) @(negedge clk);
        checkOutput("pos_after_load", {24'd0, pos}, 32'h80);

        $display("[TB] clear mid-count with A=B=1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4);
        clear = 1'b1;
        #1;
        checkOutput("clear_pos", {24'd0, pos}, 0);
        checkOutput("clear_dir", {31'd0, dir}, 0);
        checkOutput("clear_step", {31'd0, step}, 0);
        checkOutput("clear_err", {31'd0, err}, 0);
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rearm_pos", {24'd0, pos}, 0);
        checkOutput("rearm_dir", {31'd0, dir}, 0);

        $display("[TB] first edge after re-arm");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 10);

        waitDrain(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
